// File: rtl/cache_control_pkg.sv
// Shared types for the two-way cache controller: FSM states, field widths and
// physical-memory address select encodings.
package cache_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int TAG_W           = 9;
    localparam int DEFAULT_INDEX_W = 3;

    localparam logic [1:0] ADDR_SEL_CPU = 2'b00;
    localparam logic [1:0] ADDR_SEL_W1  = 2'b01;
    localparam logic [1:0] ADDR_SEL_W2  = 2'b10;

endpackage

// File: rtl/cache_control_if.sv
// CPU request / tag-compare / physical-memory handshake bundle of the cache controller.
// master drives requests and datapath status; slave is the controller.
interface cache_control_if
    import cache_types::*;
#(
    parameter int INDEX_W = DEFAULT_INDEX_W
);
    logic               mem_read;
    logic               mem_write;
    logic [INDEX_W-1:0] mem_index;
    logic               hit;
    logic               w2_hit;
    logic               w1_dirty_out;
    logic               w2_dirty_out;
    logic               pmem_resp;
    logic               mem_resp;
    logic               pmem_read;
    logic               pmem_write;
    logic [1:0]         pmem_addr_sel;
    logic               load_w1;
    logic               load_w2;
    logic               data_in_sel;
    logic               dirty_in;

    modport master (
        output mem_read, mem_write, mem_index, hit, w2_hit,
               w1_dirty_out, w2_dirty_out, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_w1, load_w2, data_in_sel, dirty_in
    );

    modport slave (
        input  mem_read, mem_write, mem_index, hit, w2_hit,
               w1_dirty_out, w2_dirty_out, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_w1, load_w2, data_in_sel, dirty_in
    );

endinterface

// File: rtl/cache_control_lru_array.sv
// One LRU bit per set; bit value names the least-recently-used way (0 way 1, 1 way 2).
module lru_array
    import cache_types::*;
#(
    parameter int INDEX_W = DEFAULT_INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    output logic               rd_data,
    input  logic               we,
    input  logic               wr_data
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0] lru_q;
    logic [SETS-1:0] lru_d;

    assign rd_data = lru_q[index];

    always_comb begin
        lru_d = lru_q;
        if (we) begin
            lru_d[index] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit service, dirty writeback, line allocate.
// Define CACHE_PERF_CNT_EN to add saturating access/miss counters.
module cache_control
    import cache_types::*;
#(
    parameter int INDEX_W = DEFAULT_INDEX_W,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_control_if.slave   bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] access_count,
    output logic [CNT_W-1:0] miss_count
`endif
);
    state_t state_q, state_d;
    logic   victim_q, victim_d;
    logic   req;
    logic   lru_rd;
    logic   lru_we;
    logic   lru_wdata;
    logic   victim_dirty;
    logic   miss_start;

    assign req          = bus.mem_read | bus.mem_write;
    assign victim_dirty = lru_rd ? bus.w2_dirty_out : bus.w1_dirty_out;

    lru_array #(.INDEX_W(INDEX_W)) u_lru (
        .clk     (clk),
        .rst     (rst),
        .index   (bus.mem_index),
        .rd_data (lru_rd),
        .we      (lru_we),
        .wr_data (lru_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        lru_we            = 1'b0;
        lru_wdata         = 1'b0;
        miss_start        = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = ADDR_SEL_CPU;
        bus.load_w1       = 1'b0;
        bus.load_w2       = 1'b0;
        bus.data_in_sel   = 1'b0;
        bus.dirty_in      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req && bus.hit) begin
                        bus.mem_resp = 1'b1;
                        lru_we       = 1'b1;
                        lru_wdata    = ~bus.w2_hit;
                        if (bus.mem_write) begin
                            bus.load_w1  = ~bus.w2_hit;
                            bus.load_w2  = bus.w2_hit;
                            bus.dirty_in = 1'b1;
                        end
                    end else if (req) begin
                        // Victim is latched so a moving index cannot retarget an open miss.
                        miss_start = 1'b1;
                        victim_d   = lru_rd;
                        state_d    = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = victim_q ? ADDR_SEL_W2 : ADDR_SEL_W1;
                    if (bus.pmem_resp) begin
                        state_d = req ? ALLOCATE : IDLE;
                    end
                end
                ALLOCATE: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        // An abandoned request leaves no line to install.
                        bus.load_w1     = req & ~victim_q;
                        bus.load_w2     = req & victim_q;
                        bus.data_in_sel = 1'b1;
                        state_d         = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] access_count_q, access_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    always_comb begin
        access_count_d = access_count_q;
        miss_count_d   = miss_count_q;
        if (bus.mem_resp && (access_count_q != '1)) begin
            access_count_d = access_count_q + CNT_W'(1);
        end
        if (miss_start && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            access_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            access_count_q <= access_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign access_count = access_count_q;
    assign miss_count   = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control; perf-counter scenario runs
// only when CACHE_PERF_CNT_EN is defined.
module tb_cache_control;
    localparam logic [8:0] NONE     = 9'h000;
    localparam logic [8:0] MEM_RESP = 9'h100;
    localparam logic [8:0] PREAD    = 9'h080;
    localparam logic [8:0] PWRITE   = 9'h040;
    localparam logic [8:0] SEL_W2   = 9'h020;
    localparam logic [8:0] SEL_W1   = 9'h010;
    localparam logic [8:0] LW1      = 9'h008;
    localparam logic [8:0] LW2      = 9'h004;
    localparam logic [8:0] DSEL     = 9'h002;
    localparam logic [8:0] DIRTY    = 9'h001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cache_control_if #(.INDEX_W(3)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] access_count;
    logic [15:0] miss_count;
    cache_control dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .access_count (access_count),
        .miss_count   (miss_count)
    );
`else
    cache_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel,
                bus.load_w1, bus.load_w2, bus.data_in_sel, bus.dirty_in};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_index    = 3'd0;
        bus.hit          = 1'b0;
        bus.w2_hit       = 1'b0;
        bus.w1_dirty_out = 1'b0;
        bus.w2_dirty_out = 1'b0;
        bus.pmem_resp    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.mem_read = 1'b1;
        bus.hit      = 1'b1;
        cyc();
        cyc();
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", outs(), NONE);
        end
        n_checks++;
        if (dut.u_lru.lru_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lru: got %h want %h", dut.u_lru.lru_q, 8'h00);
        end
`ifdef CACHE_PERF_CNT_EN
        n_checks++;
        if (access_count !== 16'd0 || miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h want 0/0", access_count, miss_count);
        end
`endif
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_idle_no_req();
        cyc();
        bus.hit = 1'b1; bus.w2_hit = 1'b1; bus.w1_dirty_out = 1'b1; bus.w2_dirty_out = 1'b1;
        bus.mem_index = 3'd4;
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h want %h", outs(), NONE);
        end
        cyc();
        n_checks++;
        if (dut.u_lru.lru_q !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_lru: got %h want %h", dut.u_lru.lru_q, 8'h00);
        end
        idle_inputs();
    endtask

    task automatic test_read_miss_clean();
        cyc();
        bus.mem_read = 1'b1; bus.mem_index = 3'd3; bus.w2_dirty_out = 1'b1;
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL rmiss_idle: got %h want %h", outs(), NONE);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.pmem_resp = (i == 3);
            settle();
            n_checks++;
            if (outs() !== ((i == 3) ? (PREAD | LW1 | DSEL) : PREAD)) begin
                n_fail++;
                $display("FAIL rmiss_alloc%0d: got %h want %h", i, outs(),
                         (i == 3) ? (PREAD | LW1 | DSEL) : PREAD);
            end
        end
        cyc();
        bus.pmem_resp = 1'b0; bus.hit = 1'b1; bus.w2_hit = 1'b0;
        settle();
        n_checks++;
        if (outs() !== MEM_RESP) begin
            n_fail++;
            $display("FAIL rmiss_complete: got %h want %h", outs(), MEM_RESP);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (dut.u_lru.lru_q[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL rmiss_lru3: got %b want 1", dut.u_lru.lru_q[3]);
        end
    endtask

    task automatic test_read_hit();
        bus.mem_read = 1'b1; bus.mem_index = 3'd2; bus.hit = 1'b1; bus.w2_hit = 1'b0;
        settle();
        n_checks++;
        if (outs() !== MEM_RESP) begin
            n_fail++;
            $display("FAIL rhit_outputs: got %h want %h", outs(), MEM_RESP);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (dut.u_lru.lru_q[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rhit_lru2: got %b want 1", dut.u_lru.lru_q[2]);
        end
    endtask

    task automatic test_write_hit_w2();
        bus.mem_write = 1'b1; bus.mem_index = 3'd2; bus.hit = 1'b1; bus.w2_hit = 1'b1;
        settle();
        n_checks++;
        if (outs() !== (MEM_RESP | LW2 | DIRTY)) begin
            n_fail++;
            $display("FAIL whit_outputs: got %h want %h", outs(), MEM_RESP | LW2 | DIRTY);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (dut.u_lru.lru_q[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL whit_lru2: got %b want 0", dut.u_lru.lru_q[2]);
        end
    endtask

    task automatic test_both_strobes();
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.mem_index = 3'd5;
        bus.hit = 1'b1; bus.w2_hit = 1'b0;
        settle();
        n_checks++;
        if (outs() !== (MEM_RESP | LW1 | DIRTY)) begin
            n_fail++;
            $display("FAIL both_outputs: got %h want %h", outs(), MEM_RESP | LW1 | DIRTY);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (dut.u_lru.lru_q[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL both_lru5: got %b want 1", dut.u_lru.lru_q[5]);
        end
    endtask

    task automatic test_dirty_miss();
        bus.mem_read = 1'b1; bus.mem_index = 3'd5; bus.w2_dirty_out = 1'b1;
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL dmiss_idle: got %h want %h", outs(), NONE);
        end
        cyc();
        n_checks++;
        if (outs() !== (PWRITE | SEL_W2)) begin
            n_fail++;
            $display("FAIL dmiss_wb0: got %h want %h", outs(), PWRITE | SEL_W2);
        end
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        n_checks++;
        if (outs() !== (PWRITE | SEL_W2)) begin
            n_fail++;
            $display("FAIL dmiss_wb1: got %h want %h", outs(), PWRITE | SEL_W2);
        end
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        n_checks++;
        if (outs() !== PREAD) begin
            n_fail++;
            $display("FAIL dmiss_alloc0: got %h want %h", outs(), PREAD);
        end
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        n_checks++;
        if (outs() !== (PREAD | LW2 | DSEL)) begin
            n_fail++;
            $display("FAIL dmiss_alloc1: got %h want %h", outs(), PREAD | LW2 | DSEL);
        end
        cyc();
        bus.pmem_resp = 1'b0; bus.hit = 1'b1; bus.w2_hit = 1'b1;
        settle();
        n_checks++;
        if (outs() !== MEM_RESP) begin
            n_fail++;
            $display("FAIL dmiss_complete: got %h want %h", outs(), MEM_RESP);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (dut.u_lru.lru_q[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL dmiss_lru5: got %b want 0", dut.u_lru.lru_q[5]);
        end
    endtask

    task automatic test_drop_in_writeback();
        bus.mem_read = 1'b1; bus.mem_index = 3'd7; bus.w1_dirty_out = 1'b1;
        cyc();
        bus.mem_read = 1'b0;
        settle();
        n_checks++;
        if (outs() !== (PWRITE | SEL_W1)) begin
            n_fail++;
            $display("FAIL dropwb_hold: got %h want %h", outs(), PWRITE | SEL_W1);
        end
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        n_checks++;
        if (outs() !== (PWRITE | SEL_W1)) begin
            n_fail++;
            $display("FAIL dropwb_resp: got %h want %h", outs(), PWRITE | SEL_W1);
        end
        cyc();
        idle_inputs();
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL dropwb_idle: got %h want %h", outs(), NONE);
        end
    endtask

    task automatic test_drop_in_allocate();
        bus.mem_read = 1'b1; bus.mem_index = 3'd6;
        cyc();
        bus.mem_read = 1'b0;
        settle();
        n_checks++;
        if (outs() !== PREAD) begin
            n_fail++;
            $display("FAIL dropal_hold: got %h want %h", outs(), PREAD);
        end
        cyc();
        bus.pmem_resp = 1'b1;
        settle();
        n_checks++;
        if ((outs() & (MEM_RESP | PREAD | PWRITE)) !== PREAD) begin
            n_fail++;
            $display("FAIL dropal_resp: got %h want %h", outs() & (MEM_RESP | PREAD | PWRITE), PREAD);
        end
        cyc();
        idle_inputs();
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL dropal_idle: got %h want %h", outs(), NONE);
        end
    endtask

    task automatic test_reset_in_writeback();
        bus.mem_read = 1'b1; bus.mem_index = 3'd4; bus.w1_dirty_out = 1'b1;
        cyc();
        settle();
        n_checks++;
        if (outs() !== (PWRITE | SEL_W1)) begin
            n_fail++;
            $display("FAIL rstwb_pre: got %h want %h", outs(), PWRITE | SEL_W1);
        end
        rst = 1'b1;
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL rstwb_during: got %h want %h", outs(), NONE);
        end
        cyc();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_checks++;
        if (outs() !== NONE) begin
            n_fail++;
            $display("FAIL rstwb_after: got %h want %h", outs(), NONE);
        end
        n_checks++;
        if (dut.u_lru.lru_q !== 8'h00) begin
            n_fail++;
            $display("FAIL rstwb_lru: got %h want %h", dut.u_lru.lru_q, 8'h00);
        end
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_perf_counters();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.mem_read = 1'b1; bus.mem_index = 3'd0; bus.hit = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.mem_index = 3'd1; bus.hit = 1'b0;
        cyc();
        bus.pmem_resp = 1'b1;
        cyc();
        bus.pmem_resp = 1'b0; bus.hit = 1'b1;
        cyc();
        idle_inputs();
        n_checks++;
        if (access_count !== 16'd4 || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d/%0d want 4/1", access_count, miss_count);
        end
        bus.mem_read = 1'b1; bus.hit = 1'b1;
        for (int i = 0; i < 65531; i++) cyc();
        n_checks++;
        if (access_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_reach_max: got %h want %h", access_count, 16'hFFFF);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (access_count !== 16'hFFFF || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL perf_saturate: got %h/%h want ffff/0001", access_count, miss_count);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_idle_no_req();
        test_read_miss_clean();
        test_read_hit();
        test_write_hit_w2();
        test_both_strobes();
        test_dirty_miss();
        test_drop_in_writeback();
        test_drop_in_allocate();
        test_reset_in_writeback();
`ifdef CACHE_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter INDEX_W, default 3, set index width (8 sets).
REQ-002 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-006 SHALL have ports: mem_index  in  INDEX_W  set index of CPU address.
REQ-007 SHALL have ports: hit, w2_hit  in  1 each  from tag compare; w2_hit=1 means way 2 hit.
REQ-008 SHALL have ports: w1_dirty_out, w2_dirty_out  in  1 each  dirty bits of indexed set.
REQ-009 SHALL have ports: pmem_resp  in  1  physical memory transfer done.
REQ-010 SHALL have ports: mem_resp, pmem_read, pmem_write  out  1 each.
REQ-011 SHALL have ports: pmem_addr_sel  out  2  00 CPU line, 01 way-1 tag line, 10 way-2 tag line.
REQ-012 SHALL have ports: load_w1, load_w2  out  1 each  write data/tag/valid/dirty of way.
REQ-013 SHALL have ports: data_in_sel  out  1  0 CPU write merge, 1 pmem line; dirty_in  out  1.

Function
REQ-014 SHALL implement states IDLE, WRITEBACK, ALLOCATE (enum in package).
REQ-015 In IDLE with request and hit: mem_resp=1 same cycle (combinational), stay IDLE.
REQ-016 Write hit: load hit way (w2_hit selects way 2), data_in_sel=0, dirty_in=1, same cycle.
REQ-017 On every hit, lru[mem_index] SHALL become the non-hit way at next edge.
REQ-018 Victim = lru[mem_index] (0 way 1, 1 way 2).
REQ-019 Miss with dirty victim: IDLE->WRITEBACK; clean victim: IDLE->ALLOCATE.
REQ-020 WRITEBACK: pmem_write=1, pmem_addr_sel = victim tag line; on pmem_resp -> ALLOCATE.
REQ-021 ALLOCATE: pmem_read=1, pmem_addr_sel=00; on pmem_resp load victim way, data_in_sel=1, dirty_in=0, -> IDLE.
REQ-022 After ALLOCATE, IDLE SHALL re-evaluate and complete as a hit; miss latency = pmem cycles + 1.
REQ-023 mem_read and mem_write both high SHALL be treated as write.
REQ-024 Request dropped mid-miss: current pmem transaction SHALL complete, then IDLE, no mem_resp.
REQ-025 All outputs not named for a state SHALL be 0; pmem_read and pmem_write never both 1.
REQ-026 No request in IDLE: all outputs 0, LRU unchanged.

Reset
REQ-027 rst SHALL force IDLE next edge, regardless of state, including mid pmem transaction.
REQ-028 rst SHALL clear every LRU bit to 0 and all counters to 0.
REQ-029 During rst cycle all outputs SHALL be 0.

Configuration
REQ-030 Macro CACHE_PERF_CNT_EN defined: outputs access_count, miss_count (CNT_W each) present.
REQ-031 access_count +1 per mem_resp; miss_count +1 per IDLE->WRITEBACK/ALLOCATE transition; both saturate at all-ones.
REQ-032 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-033 Package cache_types SHALL hold state enum, TAG_W=9, INDEX_W default, pmem_addr_sel encodings.
REQ-034 Sub-module lru_array (2^INDEX_W x 1 bit, sync reset, read index, write enable/data) SHALL hold LRU state.

Verification
REQ-035 Reset, read index 3 both ways invalid (hit=0), lru=0 -> ALLOCATE, pmem_read; pmem_resp after 4 cycles -> load_w1, then mem_resp next cycle.
REQ-036 Read hit way 1 index 2 -> mem_resp same cycle, lru[2]=1 next edge, no pmem activity.
REQ-037 Write hit way 2 -> load_w2=1, dirty_in=1, data_in_sel=0, mem_resp same cycle.
REQ-038 Miss, victim way 2 dirty -> pmem_write, addr_sel=10 until pmem_resp, then pmem_read, addr_sel=00, load_w2.
REQ-039 rst asserted in WRITEBACK -> IDLE next edge, pmem_write=0, lru all 0.
REQ-040 CACHE_PERF_CNT_EN: 3 hits + 1 miss -> access_count=4, miss_count=1; preset to 0xFFFF, hit -> stays 0xFFFF.
